// File: rtl/sec_timer_if.sv
// sec_timer_if -- button inputs and seconds-counter outputs of sec_timer.
//
// Signals:
//   btn_run   start/stop button level (asynchronous to clk)
//   btn_clr   clear button level (asynchronous to clk)
//   btn_adj   manual +1 button level (asynchronous to clk)
//   cnt_s     current seconds, binary 0..MAX_S
//   carry_m   one-cycle pulse on an automatic MAX_S->0 wrap
//   tick_1hz  one-cycle pulse per elapsed second while running
//   running   high while the timer is in RUN
//
// Modports:
//   master  drives the buttons and observes the counter (panel / bench side)
//   slave   the timer itself
interface sec_timer_if;
  logic       btn_run;
  logic       btn_clr;
  logic       btn_adj;
  logic [5:0] cnt_s;
  logic       carry_m;
  logic       tick_1hz;
  logic       running;

  modport master (
    output btn_run, btn_clr, btn_adj,
    input  cnt_s, carry_m, tick_1hz, running
  );

  modport slave (
    input  btn_run, btn_clr, btn_adj,
    output cnt_s, carry_m, tick_1hz, running
  );
endinterface

// File: rtl/sec_timer.sv
// sec_timer -- seconds time-base and 0..MAX_S counter for the seconds display.
//
// Divides clk down to a once-per-second tick while running, counts seconds,
// and emits a one-cycle carry to the minutes stage on each MAX_S->0 wrap.
// Three debounced-level buttons are synchronised and edge-detected:
// start/stop toggles the state, clear zeroes count and prescaler, and
// adjust adds one second while stopped.
//
// Parameters:
//   CLK_FREQ  clk cycles per second (>= 2)
//   MAX_S     terminal count; cnt_s wraps from MAX_S to 0
//
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous active-high reset
//   bus   sec_timer_if.slave: buttons in, cnt_s/carry_m/tick_1hz/running out
module sec_timer #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int MAX_S    = 59
) (
  input  logic        clk,
  input  logic        rst,
  sec_timer_if.slave  bus
);

  localparam int             PW       = $clog2(CLK_FREQ);
  localparam logic [PW-1:0]  PRE_TERM = PW'(CLK_FREQ - 1);
  localparam logic [5:0]     CNT_MAX  = 6'(MAX_S);

  typedef enum logic {STOP, RUN} state_t;

  // Button bit order everywhere below: [0]=run, [1]=clr, [2]=adj.
  logic [2:0] btn;
  logic [2:0] s1, s2, s3;
  logic [2:0] armed;
  logic [1:0] fill;
  logic [2:0] ev;
  logic       ev_run, ev_clr, ev_adj;

  state_t        state;
  logic [PW-1:0] presc;
  logic [5:0]    cnt;
  logic [5:0]    cnt_inc;
  logic          carry;
  logic          tick;
  logic          run_flag;

  assign btn = {bus.btn_adj, bus.btn_clr, bus.btn_run};

  // Synchroniser, delay register and re-arm logic for all three buttons.
  // NOTE: every register below is updated with non-blocking assignments so
  // s1->s2->s3 shift by exactly one stage per edge regardless of statement
  // order; blocking assignments here would collapse the chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1    <= '0;
      s2    <= '0;
      s3    <= '0;
      fill  <= '0;
      armed <= '0;
    end else begin
      s1   <= btn;
      s2   <= s1;
      s3   <= s2;
      fill <= {fill[0], 1'b1};
      // A button is armed only once s2 has shown a genuine low sample. The
      // zeros left in s1/s2 by reset are not samples, so a button held
      // through reset release stays silent until it is released and pressed.
      armed <= armed | (~s2 & {3{fill[1]}});
    end
  end

  assign ev     = s2 & ~s3 & armed;
  assign ev_run = ev[0];
  assign ev_clr = ev[1];
  assign ev_adj = ev[2];

  assign cnt_inc = (cnt == CNT_MAX) ? 6'd0 : cnt + 6'd1;

  // State machine, prescaler and seconds counter. All decisions use the
  // pre-edge state, so a STOP->RUN toggle on the same edge as adjust still
  // lets the adjust through, and a RUN->STOP toggle on a terminal edge still
  // produces that tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= STOP;
      presc    <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      tick     <= 1'b0;
      run_flag <= 1'b0;
    end else begin
      tick  <= 1'b0;
      carry <= 1'b0;

      if (ev_run) begin
        state    <= (state == RUN) ? STOP : RUN;
        run_flag <= (state != RUN);
      end

      if (ev_clr) begin
        // Clear wins over tick and adjust on the same edge.
        cnt   <= '0;
        presc <= '0;
      end else if (state == RUN) begin
        if (presc == PRE_TERM) begin
          tick  <= 1'b1;
          carry <= (cnt == CNT_MAX);
          cnt   <= cnt_inc;
          if (!ev_run) presc <= '0;
        end else if (!ev_run) begin
          presc <= presc + PW'(1);
        end
      end else begin
        // Entering RUN restarts the second from zero so the first tick is
        // exactly CLK_FREQ cycles after the toggle edge.
        if (ev_run) presc <= '0;
        if (ev_adj) cnt   <= cnt_inc;
      end
    end
  end

  assign bus.cnt_s    = cnt;
  assign bus.carry_m  = carry;
  assign bus.tick_1hz = tick;
  assign bus.running  = run_flag;

endmodule

// File: tb/tb_sec_timer.sv
// tb_sec_timer -- self-checking bench for sec_timer with CLK_FREQ=4.
//
// A behavioural model tracks the timer from the button levels the bench
// applies: a press is recognised two edges after the edge that first samples
// it high (provided the button was seen low after reset), and its effect
// follows the start/stop/clear/adjust rules on whole-second arithmetic.
module tb_sec_timer;

  localparam int F   = 4;
  localparam int MAX = 59;

  logic clk = 1'b0;
  logic rst = 1'b0;

  sec_timer_if bus ();

  sec_timer #(.CLK_FREQ(F), .MAX_S(MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int         m_cnt;
  int         m_ph;      // cycles elapsed in the current second
  bit         m_run;
  bit         m_tick;
  bit         m_carry;
  logic [3:0] hist [3];  // sampled button levels, [0] newest
  int         nsamp;     // samples taken since reset release

  bit seen_tick, seen_carry;
  int max_cnt;

  function automatic logic [8:0] dut_vec();
    return {bus.cnt_s, bus.carry_m, bus.tick_1hz, bus.running};
  endfunction

  function automatic logic [8:0] mdl_vec();
    return {6'(m_cnt), m_carry, m_tick, m_run};
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_ph = 0; m_run = 0; m_tick = 0; m_carry = 0; nsamp = 0;
    for (int i = 0; i < 3; i++) hist[i] = '0;
  endtask

  // One clock edge: advance the model, then settle 1 time unit past the edge.
  task automatic step();
    logic [2:0] lv;
    logic [2:0] ev;
    @(posedge clk);
    lv = {bus.btn_adj, bus.btn_clr, bus.btn_run};
    if (rst) begin
      model_reset();
    end else begin
      nsamp++;
      for (int i = 0; i < 3; i++) begin
        hist[i] = {hist[i][2:0], lv[i]};
        ev[i]   = hist[i][2] & ~hist[i][3] & (nsamp >= 4);
      end
      m_tick = 0; m_carry = 0;
      if (ev[1]) begin
        m_cnt = 0; m_ph = 0;
      end else if (m_run) begin
        if (m_ph == F - 1) begin
          m_tick  = 1;
          m_carry = (m_cnt == MAX);
          m_cnt   = (m_cnt + 1) % (MAX + 1);
          if (!ev[0]) m_ph = 0;
        end else if (!ev[0]) begin
          m_ph = m_ph + 1;
        end
      end else begin
        if (ev[0]) m_ph = 0;
        if (ev[2]) m_cnt = (m_cnt + 1) % (MAX + 1);
      end
      if (ev[0]) m_run = !m_run;
    end
    #1;
    seen_tick  |= bus.tick_1hz;
    seen_carry |= bus.carry_m;
    if (int'(bus.cnt_s) > max_cnt) max_cnt = int'(bus.cnt_s);
  endtask

  // mask bits: [0]=run, [1]=clr, [2]=adj
  task automatic press(input logic [2:0] mask, input int low_cyc);
    {bus.btn_adj, bus.btn_clr, bus.btn_run} = mask;
    step();
    {bus.btn_adj, bus.btn_clr, bus.btn_run} = 3'b000;
    repeat (low_cyc) step();
  endtask

  task automatic ensure_stop();
    if (m_run) press(3'b001, 2);
  endtask

  task automatic adj_to(input int target);
    int n;
    n = (target - m_cnt + MAX + 1) % (MAX + 1);
    repeat (n) press(3'b100, $urandom_range(1, 2));
    repeat (2) step();
  endtask

  task automatic test_reset();
    {bus.btn_adj, bus.btn_clr, bus.btn_run} = 3'b000;
    #1 rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (dut_vec() !== 9'd0) begin
      errors++;
      $display("FAIL reset_async: got %h expected %h", dut_vec(), 9'd0);
    end
    repeat (3) step();
    rst = 1'b0;
    repeat (3) step();
    checks++;
    if (dut_vec() !== mdl_vec()) begin
      errors++;
      $display("FAIL reset_idle: got %h expected %h", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_run_ticks();
    bus.btn_run = 1'b1;
    step();
    bus.btn_run = 1'b0;
    step();
    step();
    checks++;
    if (bus.running !== 1'b1 || dut_vec() !== mdl_vec()) begin
      errors++;
      $display("FAIL run_latency: got %h expected %h", dut_vec(), mdl_vec());
    end
    for (int sec = 1; sec <= 3; sec++) begin
      for (int c = 1; c <= F; c++) begin
        step();
        checks++;
        if (bus.tick_1hz !== (c == F) || dut_vec() !== mdl_vec()) begin
          errors++;
          $display("FAIL run_tick s%0d c%0d: got %h expected %h", sec, c, dut_vec(), mdl_vec());
        end
      end
      checks++;
      if (bus.cnt_s !== 6'(sec)) begin
        errors++;
        $display("FAIL run_count: got %0d expected %0d", bus.cnt_s, sec);
      end
    end
    ensure_stop();
  endtask

  task automatic test_wrap();
    int carries;
    ensure_stop();
    adj_to(58);
    checks++;
    if (bus.cnt_s !== 6'd58) begin
      errors++;
      $display("FAIL wrap_preset: got %0d expected 58", bus.cnt_s);
    end
    max_cnt = 0;
    carries = 0;
    press(3'b001, 2);
    for (int c = 0; c < 3 * F; c++) begin
      step();
      if (bus.carry_m) carries++;
      checks++;
      if (dut_vec() !== mdl_vec() || (bus.carry_m && !bus.tick_1hz)) begin
        errors++;
        $display("FAIL wrap_cycle %0d: got %h expected %h", c, dut_vec(), mdl_vec());
      end
    end
    checks++;
    if (carries != 1 || max_cnt > MAX || bus.cnt_s !== 6'd1) begin
      errors++;
      $display("FAIL wrap_summary: got carries=%0d max=%0d cnt=%0d expected 1/<=59/1",
               carries, max_cnt, bus.cnt_s);
    end
    ensure_stop();
  endtask

  task automatic test_adj_61();
    ensure_stop();
    press(3'b010, 2);
    checks++;
    if (bus.cnt_s !== 6'd0 || bus.running !== 1'b0) begin
      errors++;
      $display("FAIL adj_start: got cnt=%0d run=%b expected 0/0", bus.cnt_s, bus.running);
    end
    seen_tick = 0; seen_carry = 0;
    repeat (61) press(3'b100, $urandom_range(1, 3));
    repeat (2) step();
    checks++;
    if (bus.cnt_s !== 6'd1 || seen_tick || seen_carry || dut_vec() !== mdl_vec()) begin
      errors++;
      $display("FAIL adj_61: got cnt=%0d tick_seen=%b carry_seen=%b expected 1/0/0",
               bus.cnt_s, seen_tick, seen_carry);
    end
  endtask

  task automatic test_clr_terminal();
    int guard;
    ensure_stop();
    press(3'b010, 2);
    adj_to(30);
    press(3'b001, 2);
    guard = 0;
    while (!(m_run && m_ph == 1) && guard < 20) begin
      step();
      guard++;
    end
    checks++;
    if (guard >= 20) begin
      errors++;
      $display("FAIL clr_align: got timeout expected prescaler phase 1");
    end
    bus.btn_clr = 1'b1;
    step();
    bus.btn_clr = 1'b0;
    step();
    step();
    checks++;
    if (bus.cnt_s !== 6'd0 || bus.tick_1hz !== 1'b0 || bus.running !== 1'b1 ||
        dut_vec() !== mdl_vec()) begin
      errors++;
      $display("FAIL clr_terminal: got %h expected cnt=0 tick=0 running=1 (%h)",
               dut_vec(), mdl_vec());
    end
    for (int c = 1; c <= F; c++) begin
      step();
      checks++;
      if (bus.tick_1hz !== (c == F) || dut_vec() !== mdl_vec()) begin
        errors++;
        $display("FAIL clr_next_tick c%0d: got %h expected %h", c, dut_vec(), mdl_vec());
      end
    end
    checks++;
    if (bus.cnt_s !== 6'd1) begin
      errors++;
      $display("FAIL clr_after: got %0d expected 1", bus.cnt_s);
    end
    ensure_stop();
  endtask

  task automatic test_back_to_back();
    int  toggles;
    logic prev;
    ensure_stop();
    toggles = 0;
    prev = bus.running;
    bus.btn_run = 1'b1;
    repeat (20) begin
      step();
      if (bus.running !== prev) toggles++;
      prev = bus.running;
    end
    bus.btn_run = 1'b0;
    repeat (3) step();
    checks++;
    if (toggles != 1 || bus.running !== 1'b1) begin
      errors++;
      $display("FAIL run_hold: got toggles=%0d running=%b expected 1/1", toggles, bus.running);
    end
    ensure_stop();
    press(3'b010, 2);
    adj_to(12);
    checks++;
    if (bus.cnt_s !== 6'd12 || bus.running !== 1'b0) begin
      errors++;
      $display("FAIL run_clr_preset: got cnt=%0d run=%b expected 12/0", bus.cnt_s, bus.running);
    end
    press(3'b011, 1);
    step();
    checks++;
    if (bus.running !== 1'b1 || bus.cnt_s !== 6'd0 || dut_vec() !== mdl_vec()) begin
      errors++;
      $display("FAIL run_clr_same_edge: got run=%b cnt=%0d expected 1/0", bus.running, bus.cnt_s);
    end
    ensure_stop();
    // Start and adjust together from STOP: adjust still applies.
    press(3'b101, 1);
    step();
    checks++;
    if (bus.running !== 1'b1 || bus.cnt_s !== 6'd1 || dut_vec() !== mdl_vec()) begin
      errors++;
      $display("FAIL run_adj_same_edge: got run=%b cnt=%0d expected 1/1", bus.running, bus.cnt_s);
    end
    ensure_stop();
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int i = 0; i < 600; i++) begin
      bus.btn_run = ($urandom_range(0, 9) == 0);
      bus.btn_clr = ($urandom_range(0, 19) == 0);
      bus.btn_adj = ($urandom_range(0, 2) == 0);
      step();
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        errors++;
        bad++;
        if (bad <= 5)
          $display("FAIL random cycle %0d: got %h expected %h", i, dut_vec(), mdl_vec());
      end
    end
    {bus.btn_adj, bus.btn_clr, bus.btn_run} = 3'b000;
    repeat (3) step();
  endtask

  task automatic test_reset_mid();
    ensure_stop();
    press(3'b010, 2);
    adj_to(17);
    press(3'b001, 2);
    checks++;
    if (bus.cnt_s !== 6'd17 || bus.running !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_preset: got cnt=%0d run=%b expected 17/1", bus.cnt_s, bus.running);
    end
    bus.btn_adj = 1'b1;
    step();
    #2 rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (dut_vec() !== 9'd0) begin
      errors++;
      $display("FAIL rstmid_async: got %h expected %h", dut_vec(), 9'd0);
    end
    repeat (2) step();
    rst = 1'b0;
    repeat (6) step();
    checks++;
    if (bus.cnt_s !== 6'd0 || dut_vec() !== mdl_vec()) begin
      errors++;
      $display("FAIL rstmid_held: got cnt=%0d expected 0", bus.cnt_s);
    end
    bus.btn_adj = 1'b0;
    step();
    bus.btn_adj = 1'b1;
    step();
    bus.btn_adj = 1'b0;
    step();
    step();
    checks++;
    if (bus.cnt_s !== 6'd1 || dut_vec() !== mdl_vec()) begin
      errors++;
      $display("FAIL rstmid_rerise: got cnt=%0d expected 1", bus.cnt_s);
    end
  endtask

  initial begin
    model_reset();
    max_cnt = 0;
    test_reset();
    test_run_ticks();
    test_wrap();
    test_adj_61();
    test_clr_terminal();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
